// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed big-endian byte stream in, word writes out.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int MEMORY_DEPTH = 256,
    parameter int ADDR_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_reg, state_next;
    logic [7:0]         len_hi_reg, len_hi_next;
    logic [15:0]        len_reg, len_next;
    logic [CNT_W-1:0]   word_index_reg, word_index_next;
    logic [1:0]         byte_cnt_reg, byte_cnt_next;
    logic [31:0]        word_reg, word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         xor_reg, xor_next;
`endif

    logic               byte_ready_reg, byte_ready_next;
    logic               imem_we_reg, imem_we_next;
    logic [31:0]        imem_addr_reg, imem_addr_next;
    logic [31:0]        imem_wdata_reg, imem_wdata_next;
    logic               cpu_reset_reg, cpu_reset_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               error_reg, error_next;

    logic               xfer;
    logic [15:0]        len_rx;
    logic               len_ok;
    logic               last_word;
    logic [31:0]        word_assembled;

    assign xfer   = byte_valid & byte_ready_reg;
    assign len_rx = {len_hi_reg, byte_data};
    assign len_ok = (len_rx != 16'd0) && ({16'd0, len_rx} <= 32'(MEMORY_DEPTH));
    assign last_word = ({{(31 - ADDR_W){1'b0}}, word_index_reg} + 32'd1) == {16'd0, len_reg};

    // Byte lane gi receives the incoming byte when it is the (3-gi)th byte of the word (big-endian).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_assembled[gi*8 +: 8] = (byte_cnt_reg == 2'(3 - gi)) ? byte_data
                                                                             : word_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        len_hi_next     = len_hi_reg;
        len_next        = len_reg;
        word_index_next = word_index_reg;
        byte_cnt_next   = byte_cnt_reg;
        word_next       = word_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_next        = xor_reg;
`endif
        imem_we_next    = 1'b0;
        imem_addr_next  = imem_addr_reg;
        imem_wdata_next = imem_wdata_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_next = byte_data;
                    state_next  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_ok) begin
                        len_next        = len_rx;
                        word_index_next = '0;
                        byte_cnt_next   = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_next        = 8'd0;
`endif
                        state_next      = S_DATA;
                    end else begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_next = word_assembled;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_next  = xor_reg ^ byte_data;
`endif
                    if (byte_cnt_reg == 2'd3) begin
                        // Registered strobe: the write is visible during the WRITE cycle itself.
                        byte_cnt_next   = 2'd0;
                        imem_we_next    = 1'b1;
                        imem_addr_next  = {{(30 - ADDR_W){1'b0}}, word_index_reg[ADDR_W-1:0], 2'b00};
                        imem_wdata_next = word_assembled;
                        state_next      = S_WRITE;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                word_index_next = word_index_reg + CNT_W'(1);
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = S_CHECK;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) state_next = (byte_data == xor_reg) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: begin
                if (start) state_next = S_LEN_HI;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they are registered yet track the state exactly.
    always_comb begin
        byte_ready_next = 1'b0;
        busy_next       = 1'b0;
        done_next       = 1'b0;
        error_next      = 1'b0;
        cpu_reset_next  = 1'b1;
        case (state_next)
            S_LEN_HI, S_LEN_LO, S_DATA: begin
                byte_ready_next = 1'b1;
                busy_next       = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready_next = 1'b1;
                busy_next       = 1'b1;
            end
`endif
            S_WRITE: busy_next = 1'b1;
            S_DONE: begin
                done_next      = 1'b1;
                cpu_reset_next = 1'b0;
            end
            S_ERROR: error_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            len_hi_reg     <= 8'd0;
            len_reg        <= 16'd0;
            word_index_reg <= '0;
            byte_cnt_reg   <= 2'd0;
            word_reg       <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_reg        <= 8'd0;
`endif
            byte_ready_reg <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= 32'd0;
            imem_wdata_reg <= 32'd0;
            cpu_reset_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            len_hi_reg     <= len_hi_next;
            len_reg        <= len_next;
            word_index_reg <= word_index_next;
            byte_cnt_reg   <= byte_cnt_next;
            word_reg       <= word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_reg        <= xor_next;
`endif
            byte_ready_reg <= byte_ready_next;
            imem_we_reg    <= imem_we_next;
            imem_addr_reg  <= imem_addr_next;
            imem_wdata_reg <= imem_wdata_next;
            cpu_reset_reg  <= cpu_reset_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
        end
    end

    assign byte_ready = byte_ready_reg;
    assign imem_we    = imem_we_reg;
    assign imem_addr  = imem_addr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign cpu_reset  = cpu_reset_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign error      = error_reg;

endmodule
